mif_line_adapter: RTL and testbench
===================================

MIF_LINE_ADAPTER -- requirements
Module: mif_line_adapter

Interface
REQ-001 The block SHALL be clocked by clk; reset is reset, synchronous, active-high.
REQ-002 The block SHALL have parameter ADDR_BITS, default 26, memory-interface line address width.
REQ-003 The block SHALL have parameter TAG_BITS, default 5, transaction tag width.
REQ-004 The block SHALL have parameter DATA_BITS, default 64, memory-interface beat width.
REQ-005 The block SHALL have parameter BEATS, default 8, beats per line (power of two).
REQ-006 The block SHALL have these ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- line_req_valid  in  1  line request offered
- line_req_ready  out  1  line request accepted
- line_req_rw  in  1  1=write, 0=read
- line_req_addr  in  ADDR_BITS  line address
- line_req_tag  in  TAG_BITS  request tag
- line_req_data  in  DATA_BITS*BEATS  write line, beat i = bits [DATA_BITS*i +: DATA_BITS]
- line_resp_valid  out  1  read line available
- line_resp_ready  in  1  consumer accepts read line
- line_resp_data  out  DATA_BITS*BEATS  assembled read line
- line_resp_tag  out  TAG_BITS  tag of returned line
- mem_req_valid  out  1  command to memory
- mem_req_ready  in  1  memory accepts command
- mem_req_rw  out  1  command direction
- mem_req_addr  out  ADDR_BITS  command address
- mem_req_tag  out  TAG_BITS  command tag
- mem_req_data_valid  out  1  write beat valid
- mem_req_data_ready  in  1  memory accepts write beat
- mem_req_data_bits  out  DATA_BITS  write beat
- mem_resp_valid  in  1  read beat valid (no backpressure)
- mem_resp_data  in  DATA_BITS  read beat
- mem_resp_tag  in  TAG_BITS  read beat tag
- err_stray  out  1  sticky: response beat received outside RDATA or with wrong tag

Function
REQ-007 The block SHALL implement FSM states IDLE, CMD, WDATA, RDATA, RESP; one transaction in flight.
REQ-008 line_req_ready SHALL equal 1 only in IDLE; a handshake latches rw, addr, tag, full line data and moves to CMD.
REQ-009 In CMD mem_req_valid SHALL be 1 with latched rw/addr/tag held stable until mem_req_ready; on handshake go to WDATA if rw=1, else RDATA.
REQ-010 In WDATA mem_req_data_valid SHALL be 1 with beat cnt of latched line; cnt increments on each mem_req_data_ready handshake.
REQ-011 After beat BEATS-1 handshake, FSM SHALL return to IDLE; cnt wraps to 0; no line response for writes.
REQ-012 In RDATA each mem_resp_valid beat with mem_resp_tag equal to latched tag SHALL be stored into line slot cnt, cnt incrementing.
REQ-013 On storing beat BEATS-1 FSM SHALL enter RESP next cycle; cnt wraps to 0.
REQ-014 In RESP line_resp_valid SHALL be 1, data/tag stable, until line_resp_ready; then IDLE.
REQ-015 A mem_resp_valid beat in any state other than RDATA, or with tag mismatch in RDATA, SHALL be discarded and set err_stray, which stays 1 until reset.
REQ-016 Minimum latency: line request accepted cycle N -> mem_req_valid at cycle N+1; write with always-ready memory returns to IDLE (line_req_ready=1) at cycle N+2+BEATS.
REQ-017 Read beats arriving on consecutive cycles SHALL all be captured; no beat lost.
REQ-018 mem_req_valid, mem_req_data_valid, line_resp_valid SHALL never be 1 simultaneously.
REQ-019 Line requests offered while not IDLE SHALL not be accepted and not alter state.

Reset
REQ-020 Reset SHALL force IDLE, cnt=0, err_stray=0, mem_req_valid=0, mem_req_data_valid=0, line_resp_valid=0, line_req_ready=1 next cycle.
REQ-021 Reset mid-transaction SHALL abandon it silently; latched data need not be cleared.

Verification
REQ-022 Write addr=0x10 tag=3, line beats 0x0..0x7, memory always ready -> one command rw=1 addr=0x10 tag=3 then beats 0..7 on 8 consecutive cycles, IDLE after.
REQ-023 Read addr=0x20 tag=5, memory returns 8 beats 0xA0..0xA7 tag 5 -> line_resp_valid, line_resp_tag=5, slot i = 0xA0+i.
REQ-024 Read with line_resp_ready held 0 for 10 cycles -> line_resp_valid and data held stable, line_req_ready=0 throughout.
REQ-025 mem_resp_valid beat in IDLE, then tag-6 beat during tag-5 read -> both discarded, err_stray=1, read completes with correct 8 beats.
REQ-026 mem_req_ready low 4 cycles, then write with mem_req_data_ready toggling -> command/beats held stable, each beat sent exactly once in order.
REQ-027 Reset asserted after beat 3 of a read -> IDLE next cycle, line_resp_valid never asserted, err_stray=0.

Source files
------------

// File: rtl/mif_line_adapter.sv
// mif_line_adapter: bridges whole-line requests to a beat-serial memory interface, one transaction in flight.
module mif_line_adapter #(
    parameter int ADDR_BITS = 26,
    parameter int TAG_BITS  = 5,
    parameter int DATA_BITS = 64,
    parameter int BEATS     = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       line_req_valid,
    output logic                       line_req_ready,
    input  logic                       line_req_rw,
    input  logic [ADDR_BITS-1:0]       line_req_addr,
    input  logic [TAG_BITS-1:0]        line_req_tag,
    input  logic [DATA_BITS*BEATS-1:0] line_req_data,
    output logic                       line_resp_valid,
    input  logic                       line_resp_ready,
    output logic [DATA_BITS*BEATS-1:0] line_resp_data,
    output logic [TAG_BITS-1:0]        line_resp_tag,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic                       mem_req_rw,
    output logic [ADDR_BITS-1:0]       mem_req_addr,
    output logic [TAG_BITS-1:0]        mem_req_tag,
    output logic                       mem_req_data_valid,
    input  logic                       mem_req_data_ready,
    output logic [DATA_BITS-1:0]       mem_req_data_bits,
    input  logic                       mem_resp_valid,
    input  logic [DATA_BITS-1:0]       mem_resp_data,
    input  logic [TAG_BITS-1:0]        mem_resp_tag,
    output logic                       err_stray
);
    localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
    typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, RESP} state_t;
    state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic rw_q;
    logic [ADDR_BITS-1:0] addr_q;
    logic [TAG_BITS-1:0] tag_q;
    logic [DATA_BITS*BEATS-1:0] line_q;
    logic last, beat_ok, step;
    assign last = cnt == CW'(BEATS - 1);
    assign beat_ok = state == RDATA && mem_resp_valid && mem_resp_tag == tag_q;
    assign step = beat_ok || (state == WDATA && mem_req_data_ready);
    assign line_req_ready = state == IDLE;
    assign mem_req_valid = state == CMD;
    assign mem_req_rw = rw_q;
    assign mem_req_addr = addr_q;
    assign mem_req_tag = tag_q;
    assign mem_req_data_valid = state == WDATA;
    assign mem_req_data_bits = line_q[DATA_BITS*cnt +: DATA_BITS];
    assign line_resp_valid = state == RESP;
    assign line_resp_data = line_q;
    assign line_resp_tag = tag_q;
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = line_req_valid ? CMD : IDLE;
            CMD:     state_nxt = mem_req_ready ? (rw_q ? WDATA : RDATA) : CMD;
            WDATA:   state_nxt = (mem_req_data_ready && last) ? IDLE : WDATA;
            RDATA:   state_nxt = (beat_ok && last) ? RESP : RDATA;
            RESP:    state_nxt = line_resp_ready ? IDLE : RESP;
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            err_stray <= 1'b0;
        end else begin
            state <= state_nxt;
            if (step) cnt <= last ? '0 : cnt + 1'b1;
            if (mem_resp_valid && !beat_ok) err_stray <= 1'b1;
        end
    end
    // The line buffer holds write data on the way out and collects read beats on the way in.
    always_ff @(posedge clk) begin
        if (line_req_valid && line_req_ready) begin
            rw_q <= line_req_rw;
            addr_q <= line_req_addr;
            tag_q <= line_req_tag;
            line_q <= line_req_data;
        end else if (beat_ok) begin
            line_q[DATA_BITS*cnt +: DATA_BITS] <= mem_resp_data;
        end
    end
endmodule

// File: tb/tb_mif_line_adapter.sv
// tb_mif_line_adapter: table-driven transactions plus a mid-read reset sequence for mif_line_adapter.
module tb_mif_line_adapter;
    localparam int AB = 26, TB = 5, DB = 64, NB = 8, LW = DB * NB;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic line_req_valid, line_req_ready, line_req_rw;
    logic [AB-1:0] line_req_addr;
    logic [TB-1:0] line_req_tag;
    logic [LW-1:0] line_req_data;
    logic line_resp_valid, line_resp_ready;
    logic [LW-1:0] line_resp_data;
    logic [TB-1:0] line_resp_tag;
    logic mem_req_valid, mem_req_ready, mem_req_rw;
    logic [AB-1:0] mem_req_addr;
    logic [TB-1:0] mem_req_tag;
    logic mem_req_data_valid, mem_req_data_ready;
    logic [DB-1:0] mem_req_data_bits;
    logic mem_resp_valid;
    logic [DB-1:0] mem_resp_data;
    logic [TB-1:0] mem_resp_tag;
    logic err_stray;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    mif_line_adapter #(.ADDR_BITS(AB), .TAG_BITS(TB), .DATA_BITS(DB), .BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .line_req_valid(line_req_valid), .line_req_ready(line_req_ready), .line_req_rw(line_req_rw),
        .line_req_addr(line_req_addr), .line_req_tag(line_req_tag), .line_req_data(line_req_data),
        .line_resp_valid(line_resp_valid), .line_resp_ready(line_resp_ready),
        .line_resp_data(line_resp_data), .line_resp_tag(line_resp_tag),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_rw(mem_req_rw),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_req_data_valid(mem_req_data_valid), .mem_req_data_ready(mem_req_data_ready),
        .mem_req_data_bits(mem_req_data_bits),
        .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_tag(mem_resp_tag),
        .err_stray(err_stray)
    );
    task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask
    function automatic logic [LW-1:0] mk_line(input logic [DB-1:0] base);
        logic [LW-1:0] l;
        for (int i = 0; i < NB; i++) l[DB*i +: DB] = base + DB'(i);
        return l;
    endfunction
    typedef struct {
        logic rw;
        logic [AB-1:0] addr;
        logic [TB-1:0] tag;
        logic [DB-1:0] base;
        int stall;
        bit toggle;
        int hold;
        bit stray;
        int exp_cycles;
        logic exp_err;
    } vec_t;
    vec_t vecs[6];
    always @(negedge clk)
        if (!reset) chk("excl_valid", LW'($onehot0({mem_req_valid, mem_req_data_valid, line_resp_valid})), LW'(1));
    task automatic run_vec(input vec_t v);
        int cyc, sent;
        logic [LW-1:0] line;
        line = mk_line(v.base);
        if (v.stray) begin
            @(negedge clk);
            mem_resp_valid = 1'b1; mem_resp_tag = v.tag; mem_resp_data = '1;
            @(negedge clk);
            mem_resp_valid = 1'b0;
            chk("err_idle_stray", LW'(err_stray), LW'(1));
        end
        @(negedge clk);
        chk("req_ready_idle", LW'(line_req_ready), LW'(1));
        line_req_valid = 1'b1; line_req_rw = v.rw; line_req_addr = v.addr; line_req_tag = v.tag;
        line_req_data = v.rw ? line : '0;
        cyc = 0;
        @(negedge clk);
        cyc++;
        line_req_valid = 1'b0; line_req_data = '0;
        for (int s = 0; s <= v.stall; s++) begin
            if (s > 0) begin @(negedge clk); cyc++; end
            chk("cmd", LW'({mem_req_valid, mem_req_rw, mem_req_addr, mem_req_tag, line_req_ready}),
                LW'({1'b1, v.rw, v.addr, v.tag, 1'b0}));
            mem_req_ready = (s == v.stall);
        end
        @(negedge clk);
        cyc++;
        mem_req_ready = 1'b0;
        if (v.rw) begin
            sent = 0;
            for (int c = 0; c < 64 && sent < NB; c++) begin
                if (c > 0) begin @(negedge clk); cyc++; end
                chk("wbeat_valid", LW'(mem_req_data_valid), LW'(1));
                chk("wbeat_bits", LW'(mem_req_data_bits), LW'(v.base + DB'(sent)));
                mem_req_data_ready = v.toggle ? c[0] : 1'b1;
                if (mem_req_data_ready) sent++;
            end
            chk("wbeat_count", LW'(sent), LW'(NB));
            @(negedge clk);
            cyc++;
            mem_req_data_ready = 1'b0;
            chk("wdata_done", LW'({mem_req_data_valid, line_resp_valid}), LW'(0));
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (b > 0) begin @(negedge clk); cyc++; end
                chk("rd_no_resp", LW'(line_resp_valid), LW'(0));
                if (v.stray && b == 4) begin
                    mem_resp_valid = 1'b1; mem_resp_tag = 5'd6; mem_resp_data = '1;
                    @(negedge clk);
                    cyc++;
                end
                mem_resp_valid = 1'b1; mem_resp_tag = v.tag; mem_resp_data = v.base + DB'(b);
            end
            @(negedge clk);
            cyc++;
            mem_resp_valid = 1'b0;
            for (int h = 0; h <= v.hold; h++) begin
                if (h > 0) begin @(negedge clk); cyc++; end
                chk("resp_valid", LW'({line_resp_valid, line_req_ready}), LW'(2));
                chk("resp_tag", LW'(line_resp_tag), LW'(v.tag));
                chk("resp_data", line_resp_data, line);
                line_req_valid = (h < v.hold); line_req_addr = '1;
                line_resp_ready = (h == v.hold);
            end
            @(negedge clk);
            cyc++;
            line_resp_ready = 1'b0;
            chk("resp_done", LW'(line_resp_valid), LW'(0));
        end
        chk("req_ready_end", LW'(line_req_ready), LW'(1));
        chk("cycles", LW'(cyc), LW'(v.exp_cycles));
        chk("err_stray", LW'(err_stray), LW'(v.exp_err));
    endtask
    initial begin
        line_req_valid = 0; line_req_rw = 0; line_req_addr = '0; line_req_tag = '0; line_req_data = '0;
        line_resp_ready = 0; mem_req_ready = 0; mem_req_data_ready = 0;
        mem_resp_valid = 0; mem_resp_data = '0; mem_resp_tag = '0;
        repeat (2) @(negedge clk);
        chk("reset_state", LW'({line_req_ready, mem_req_valid, mem_req_data_valid, line_resp_valid, err_stray}),
            LW'(5'b10000));
        reset = 1'b0;
        vecs[0] = '{1'b1, 26'h10, 5'd3, 64'h0, 0, 1'b0, 0, 1'b0, 10, 1'b0};
        vecs[1] = '{1'b0, 26'h20, 5'd5, 64'hA0, 0, 1'b0, 0, 1'b0, 11, 1'b0};
        vecs[2] = '{1'b0, 26'h24, 5'd5, 64'hA0, 0, 1'b0, 10, 1'b0, 21, 1'b0};
        vecs[3] = '{1'b1, 26'h33, 5'd1, 64'h1000, 4, 1'b1, 0, 1'b0, 22, 1'b0};
        vecs[4] = '{1'b0, 26'h20, 5'd5, 64'hA0, 0, 1'b0, 0, 1'b1, 12, 1'b1};
        vecs[5] = '{1'b0, 26'h3FFFFFF, 5'd31, 64'hFFFFFFFFFFFFFFF8, 0, 1'b0, 0, 1'b0, 11, 1'b1};
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);
        // Abandon a read after four beats with a reset; the line must never be offered.
        @(negedge clk);
        line_req_valid = 1'b1; line_req_rw = 1'b0; line_req_addr = 26'h40; line_req_tag = 5'd2;
        @(negedge clk);
        line_req_valid = 1'b0; mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        for (int b = 0; b < 4; b++) begin
            mem_resp_valid = 1'b1; mem_resp_tag = 5'd2; mem_resp_data = 64'h70 + 64'(b);
            @(negedge clk);
        end
        mem_resp_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset", LW'({line_req_ready, mem_req_valid, mem_req_data_valid, line_resp_valid, err_stray}),
            LW'(5'b10000));
        reset = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk("no_resp_after_reset", LW'({line_resp_valid, line_req_ready}), LW'(1));
        end
        run_vec('{1'b0, 26'h40, 5'd2, 64'h55, 0, 1'b0, 0, 1'b0, 11, 1'b0});
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
